// File: rtl/wb_data_arbiter_pkg.sv
// Shared types and widths for the Wishbone data-port arbiter.
// DATA_W / ADR_W mirror the project-wide data and program-counter widths.
package wb_data_arbiter_pkg;

  localparam int DATA_W   = 32;  // data bus width
  localparam int ADR_W    = 16;  // address width
  localparam int TO_CNT_W = 5;   // BUSY-cycle counter width for the timeout option

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_data_arbiter_rr_picker.sv
// Rotating-priority encoder: returns the first requester strictly after `last_i`,
// wrapping from NUM_M-1 back to 0, so `last_i` itself has the lowest priority.
// Purely combinational.
module wb_data_arbiter_rr_picker #(
  parameter int NUM_M = 4,
  parameter int IDX_W = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             any_o
);

  logic [NUM_M-1:0] above_last;
  logic [NUM_M-1:0] pool;

  // Prefer requesters above `last`; if none, wrap around to the lowest requester.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    above_last = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (IDX_W'(k) > last_i) above_last = above_last | (NUM_M'(1) << k);
    end
    pool = ((req_i & above_last) != '0) ? (req_i & above_last) : req_i;
    winner_o = '0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      if ((pool & (NUM_M'(1) << k)) != '0) winner_o = IDX_W'(k);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/wb_data_arbiter.sv
// Round-robin arbiter merging NUM_M classic-Wishbone data masters onto one slave port.
// One single-beat transfer per grant; the slave ack is returned to the granted master
// only, read data is broadcast to all masters.
// Optional feature: define WB_ARB_TIMEOUT_EN to abort a transfer the slave never acks
// after TIMEOUT BUSY cycles and flag it on m_err_o. Without it BUSY waits forever and
// m_err_o is tied low.
module wb_data_arbiter
  import wb_data_arbiter_pkg::*;
#(
  parameter int NUM_M   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_M-1:0]        m_cyc_i,
  input  logic [NUM_M-1:0]        m_stb_i,
  input  logic [NUM_M-1:0]        m_we_i,
  input  logic [NUM_M*ADR_W-1:0]  m_adr_i,
  input  logic [NUM_M*DATA_W-1:0] m_dat_i,
  output logic [NUM_M-1:0]        m_ack_o,
  output logic [NUM_M-1:0]        m_err_o,
  output logic [DATA_W-1:0]       m_dat_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADR_W-1:0]        s_adr_o,
  output logic [DATA_W-1:0]       s_dat_o,
  input  logic                    s_ack_i,
  input  logic [DATA_W-1:0]       s_dat_i
);

  localparam int IDX_W = $clog2(NUM_M);

  // Reject unsupported configurations at elaboration time.
  if (NUM_M < 2 || NUM_M > 4 || TIMEOUT < 2 || TIMEOUT > (1 << TO_CNT_W)) begin : g_bad_param
    $error("wb_data_arbiter: NUM_M must be 2..4 and TIMEOUT 2..32");
  end

  // Per-master views of the packed address/data buses.
  logic [ADR_W-1:0]  m_adr [NUM_M];
  logic [DATA_W-1:0] m_dat [NUM_M];

  for (genvar k = 0; k < NUM_M; k++) begin : g_unpack
    assign m_adr[k] = m_adr_i[k*ADR_W +: ADR_W];
    assign m_dat[k] = m_dat_i[k*DATA_W +: DATA_W];
  end

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [ADR_W-1:0]  s_adr_q, s_adr_d;
  logic [DATA_W-1:0] s_dat_q, s_dat_d;
  logic              s_we_q, s_we_d;

  logic [NUM_M-1:0]  req;
  logic [IDX_W-1:0]  winner;
  logic              any_req;
  logic [NUM_M-1:0]  grant_onehot;
  logic              busy;
  logic              grant_cyc;
  logic              ack_fire;
  logic              abort_fire;
  logic              timeout_fire;

  assign req          = m_cyc_i & m_stb_i;
  assign busy         = (state_q == ST_BUSY);
  assign grant_onehot = NUM_M'(1) << grant_q;
  assign grant_cyc    = |(m_cyc_i & grant_onehot);

  // An ack is only meaningful while BUSY; in IDLE it is the slave's trailing repeat.
  assign ack_fire   = busy & s_ack_i;
  // Master gave up before the slave answered; an ack in the same cycle still wins.
  assign abort_fire = busy & ~s_ack_i & ~grant_cyc;

  wb_data_arbiter_rr_picker #(
    .NUM_M (NUM_M),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

`ifdef WB_ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;

  // Count BUSY cycles; restarts from zero on every entry into BUSY.
  assign to_cnt_d     = busy ? (to_cnt_q + TO_CNT_W'(1)) : '0;
  assign timeout_fire = busy & ~s_ack_i & (to_cnt_q == TO_CNT_W'(TIMEOUT - 1));

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  // Next-state logic, latching of the winner's request, and ack/err steering.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    s_adr_d = s_adr_q;
    s_dat_d = s_dat_q;
    s_we_d  = s_we_q;
    m_ack_o = '0;
    m_err_o = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_BUSY;
          grant_d = winner;
          s_adr_d = m_adr[winner];
          s_dat_d = m_dat[winner];
          s_we_d  = |(m_we_i & (NUM_M'(1) << winner));
        end
      end
      ST_BUSY: begin
        if (ack_fire) m_ack_o = grant_onehot;
        if (timeout_fire) m_err_o = grant_onehot;
        if (ack_fire || abort_fire || timeout_fire) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_M - 1);
      s_adr_q <= '0;
      s_dat_q <= '0;
      s_we_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      s_adr_q <= s_adr_d;
      s_dat_q <= s_dat_d;
      s_we_q  <= s_we_d;
    end
  end

  assign s_cyc_o = busy;
  assign s_stb_o = busy;
  assign s_we_o  = s_we_q;
  assign s_adr_o = s_adr_q;
  assign s_dat_o = s_dat_q;
  assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_data_arbiter.sv
// Directed bench for wb_data_arbiter with a registered-ack slave model that
// repeats its ack for one cycle after the strobe drops.
module tb_wb_data_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   m_cyc, m_stb, m_we;
  logic [15:0]  adr_a [4];
  logic [31:0]  dat_a [4];
  logic [63:0]  m_adr;
  logic [127:0] m_dat;
  logic [3:0]   m_ack, m_err;
  logic [31:0]  m_rdat;
  logic         s_cyc, s_stb, s_we;
  logic [15:0]  s_adr;
  logic [31:0]  s_wdat;
  logic         s_ack;
  logic [31:0]  s_rdat;
  logic         slave_en;
  int           wr_2000_cnt = 0;
  logic [31:0]  wr_2000_dat = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  always #5 clk = ~clk;

  assign m_adr = {adr_a[3], adr_a[2], adr_a[1], adr_a[0]};
  assign m_dat = {dat_a[3], dat_a[2], dat_a[1], dat_a[0]};

  wb_data_arbiter #(.NUM_M(4), .TIMEOUT(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_we_i  (m_we),
    .m_adr_i (m_adr),
    .m_dat_i (m_dat),
    .m_ack_o (m_ack),
    .m_err_o (m_err),
    .m_dat_o (m_rdat),
    .s_cyc_o (s_cyc),
    .s_stb_o (s_stb),
    .s_we_o  (s_we),
    .s_adr_o (s_adr),
    .s_dat_o (s_wdat),
    .s_ack_i (s_ack),
    .s_dat_i (s_rdat)
  );

  // Slave: ack registered one cycle after cyc&stb, repeated while cyc&stb held.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack <= 1'b0;
    end else begin
      s_ack <= s_cyc & s_stb & slave_en;
      if (s_cyc && s_stb && s_we && s_ack && s_adr == 16'h2000) begin
        wr_2000_cnt <= wr_2000_cnt + 1;
        wr_2000_dat <= s_wdat;
      end
    end
  end

  assign s_rdat = s_ack ? {16'hA5A5, s_adr} : 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic req(input logic [1:0] k, input logic we, input logic [15:0] adr,
                     input logic [31:0] dat);
    adr_a[k] = adr;
    dat_a[k] = dat;
    m_we[k]  = we;
    m_cyc[k] = 1'b1;
    m_stb[k] = 1'b1;
  endtask

  task automatic drop(input logic [1:0] k);
    m_cyc[k] = 1'b0;
    m_stb[k] = 1'b0;
  endtask

  // Run cycles, releasing any master as soon as it is acked.
  task automatic service(input int n);
    repeat (n) begin
      step();
      m_cyc = m_cyc & ~m_ack;
      m_stb = m_stb & ~m_ack;
    end
  endtask

  function automatic int ack_idx(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  initial begin
    int n_ack;
    int idx;
    int err_early;
    bit rereq_pending;
    bit rereq_done;
    int grants[$];
    int t_ack[$];
    int exp_order[$];

    rst_n    = 1'b0;
    m_cyc    = '0;
    m_stb    = '0;
    m_we     = '0;
    slave_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      adr_a[i] = '0;
      dat_a[i] = '0;
    end

    // Reset state
    #2;
    check("rst_s_cyc", 32'(s_cyc), 32'h0);
    check("rst_s_stb", 32'(s_stb), 32'h0);
    check("rst_s_we",  32'(s_we),  32'h0);
    check("rst_s_adr", 32'(s_adr), 32'h0);
    check("rst_s_dat", s_wdat,     32'h0);
    check("rst_m_ack", 32'(m_ack), 32'h0);
    check("rst_m_err", 32'(m_err), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single master read: latency N+1 / N+2 / N+3
    req(2'd1, 1'b0, 16'h1004, 32'h0);
    step();
    check("single_stb_n1", 32'(s_stb), 32'h1);
    check("single_cyc_n1", 32'(s_cyc), 32'h1);
    check("single_adr_n1", 32'(s_adr), 32'h1004);
    check("single_we_n1",  32'(s_we),  32'h0);
    check("single_ack_n1", 32'(m_ack), 32'h0);
    step();
    check("single_ack_n2", 32'(m_ack), 32'b0010);
    check("single_rdat",   m_rdat,     32'hA5A51004);
    drop(2'd1);
    step();
    check("single_stb_n3",      32'(s_stb), 32'h0);
    check("single_trail_ack_n3", 32'(m_ack), 32'h0);
    step();

    // Write with trailing slave ack: one m_ack, one write
    req(2'd0, 1'b1, 16'h2000, 32'hDEADBEEF);
    step();
    check("wr_we",  32'(s_we), 32'h1);
    check("wr_dat", s_wdat,    32'hDEADBEEF);
    n_ack = 0;
    repeat (5) begin
      step();
      if (m_ack[0]) begin
        n_ack++;
        drop(2'd0);
      end
    end
    check("wr_ack_count",  32'(n_ack),       32'd1);
    check("wr_write_count", 32'(wr_2000_cnt), 32'd1);
    check("wr_write_data", wr_2000_dat,      32'hDEADBEEF);

    // Abort: m2 drops cyc at N+1, no ack, next grant goes to m3 over m1
    req(2'd2, 1'b0, 16'h2008, 32'h0);
    step();
    check("abort_adr_n1", 32'(s_adr), 32'h2008);
    drop(2'd2);
    step();
    check("abort_stb_n2", 32'(s_stb), 32'h0);
    check("abort_ack_n2", 32'(m_ack), 32'h0);
    req(2'd1, 1'b0, 16'h1111, 32'h0);
    req(2'd3, 1'b0, 16'h3333, 32'h0);
    step();
    check("abort_ack_n3",    32'(m_ack), 32'h0);
    check("abort_next_m3",   32'(s_adr), 32'h3333);
    service(8);

    // Reset asserted during the ack cycle of a transfer
    req(2'd2, 1'b0, 16'h2222, 32'h0);
    step();
    step();
    check("midrst_ack_before", 32'(m_ack), 32'b0100);
    rst_n = 1'b0;
    #1;
    check("midrst_stb", 32'(s_stb), 32'h0);
    check("midrst_cyc", 32'(s_cyc), 32'h0);
    check("midrst_ack", 32'(m_ack), 32'h0);
    drop(2'd2);
    step();
    rst_n = 1'b1;
    step();

    // Contention: all four request; m0 re-requests right after its ack
    for (int k = 0; k < 4; k++) req(2'(k), 1'b0, 16'h3000 + 16'(k), 32'h0);
    rereq_pending = 1'b0;
    rereq_done    = 1'b0;
    for (int b = 0; b < 40 && grants.size() < 5; b++) begin
      step();
      if (rereq_pending) begin
        req(2'd0, 1'b0, 16'h3100, 32'h0);
        rereq_pending = 1'b0;
        rereq_done    = 1'b1;
      end
      if (m_ack != 4'b0000) begin
        idx = ack_idx(m_ack);
        grants.push_back(idx);
        t_ack.push_back(cycle);
        m_cyc = m_cyc & ~m_ack;
        m_stb = m_stb & ~m_ack;
        if (idx == 0 && !rereq_done) rereq_pending = 1'b1;
      end
    end
    exp_order = '{0, 1, 2, 3, 0};
    check("cont_grant_count", 32'(grants.size()), 32'd5);
    for (int i = 0; i < grants.size(); i++) begin
      check($sformatf("cont_grant_%0d", i), 32'(grants[i]), 32'(exp_order[i]));
    end
    if (t_ack.size() == 5) check("cont_spacing", 32'(t_ack[4] - t_ack[0]), 32'd12);
    service(4);

    // Slave never acks
    slave_en = 1'b0;
    req(2'd3, 1'b0, 16'h4444, 32'h0);
    step();
    check("hang_stb_rise", 32'(s_stb), 32'h1);
`ifdef WB_ARB_TIMEOUT_EN
    err_early = 0;
    repeat (14) begin
      step();
      if (m_err != 4'b0000) err_early++;
    end
    check("to_err_early", 32'(err_early), 32'd0);
    step();
    check("to_err",     32'(m_err), 32'b1000);
    check("to_no_ack",  32'(m_ack), 32'h0);
    drop(2'd3);
    step();
    check("to_idle_stb", 32'(s_stb), 32'h0);
    check("to_err_gone", 32'(m_err), 32'h0);
`else
    err_early = 0;
    repeat (100) begin
      step();
      if (m_err != 4'b0000) err_early++;
    end
    check("hang_stb_100", 32'(s_stb), 32'h1);
    check("hang_adr_100", 32'(s_adr), 32'h4444);
    check("hang_err_100", 32'(err_early), 32'd0);
    drop(2'd3);
    step();
    check("hang_drop_idle", 32'(s_stb), 32'h0);
`endif
    slave_en = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
